// File: rtl/spi_psram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : spi_psram_responder_pkg
// Description : Opcodes, FSM state encoding and address width shared by the
//               serial PSRAM responder and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_psram_responder_pkg;

  // Supported PSRAM opcodes
  typedef enum logic [7:0] {
    PSRAM_CMD_WRITE = 8'h02,
    PSRAM_CMD_READ  = 8'h03
  } psram_cmd_t;

  // Responder transaction state
  typedef enum logic [2:0] {
    PS_IDLE    = 3'd0,
    PS_CMD     = 3'd1,
    PS_ADDR    = 3'd2,
    PS_RD_DATA = 3'd3,
    PS_WR_DATA = 3'd4,
    PS_IGNORE  = 3'd5
  } psram_state_t;

  // Width of the address field carried on the wire
  localparam int PSRAM_ADDR_BITS = 24;

endpackage
`default_nettype wire

// File: rtl/spi_psram_responder_if.sv
`default_nettype none
// ============================================================================
// Interface   : spi_psram_responder_if
// Description : SPI pin bundle between a PSRAM master and the responder,
//               plus the responder status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_psram_responder_if;
  logic sclk_in;
  logic cs_in;
  logic mosi_in;
  logic miso_out;
  logic busy_out;
  logic cmd_err_out;

  modport master (
    output sclk_in, cs_in, mosi_in,
    input  miso_out, busy_out, cmd_err_out
  );

  modport slave (
    input  sclk_in, cs_in, mosi_in,
    output miso_out, busy_out, cmd_err_out
  );
endinterface
`default_nettype wire

// File: rtl/spi_psram_responder_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_psram_responder_sync_edge
// Description : Multi-flop synchronizer for one asynchronous SPI pin followed
//               by a one-flop edge detector producing rise/fall pulses.
//               STAGES must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_psram_responder_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the synchronizer chain and remember the last level.
  // Reset value matches the pin's idle level so no edge is seen out of reset.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_psram_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_psram_responder
// Description : SPI mode-0 serial PSRAM responder. Oversamples the SPI pins in
//               the system clock domain, decodes READ/WRITE with a 24-bit
//               address and serves unlimited-length bursts from an internal
//               byte array that wraps modulo its depth.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_psram_responder
  import spi_psram_responder_pkg::*;
#(
  parameter int MEM_ADDR_W  = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  spi_psram_responder_if.slave bus
);

  localparam int MEM_DEPTH = 2 ** MEM_ADDR_W;

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  psram_state_t               state;
  logic [7:0]                 shift;
  logic [2:0]                 bit_cnt;
  logic [1:0]                 byte_cnt;
  logic [PSRAM_ADDR_BITS-1:0] addr;
  logic                       rd_cmd;
  logic                       miso_q;
  logic                       cmd_err_q;

  logic [7:0]            mem [MEM_DEPTH];
  logic [MEM_ADDR_W-1:0] mem_idx;
  logic [7:0]            rd_data;
  logic [7:0]            shift_in;
  logic                  mem_we;
  logic                  unused_ok;

  spi_psram_responder_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_in(clk_in), .reset_in(reset_in), .din(bus.sclk_in),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_psram_responder_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_in(clk_in), .reset_in(reset_in), .din(bus.cs_in),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_psram_responder_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_in(clk_in), .reset_in(reset_in), .din(bus.mosi_in),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Upper address bits beyond the array depth are simply ignored
  assign mem_idx  = addr[MEM_ADDR_W-1:0];
  assign rd_data  = mem[mem_idx];
  assign shift_in = {shift[6:0], mosi_level};
  // Write lands on the rise that completes a data byte, unless cs is leaving
  assign mem_we   = (state == PS_WR_DATA) && sclk_rise && !cs_rise && (bit_cnt == 3'd7);

  // Byte array: written only in WR_DATA, read only in RD_DATA, so never both at once
  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      mem[mem_idx] <= shift_in;
    end
  end

  // Transaction FSM: command/address decode, burst data movement, registered outputs
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state     <= PS_IDLE;
      shift     <= 8'h00;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 2'd0;
      addr      <= '0;
      rd_cmd    <= 1'b0;
      miso_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;
      if (cs_rise) begin
        // Deselect wins over any same-cycle clock edge; partial bytes are dropped
        state    <= PS_IDLE;
        miso_q   <= 1'b0;
        bit_cnt  <= 3'd0;
        byte_cnt <= 2'd0;
      end else begin
        case (state)
          PS_IDLE: begin
            miso_q <= 1'b0;
            if (cs_fall) begin
              state    <= PS_CMD;
              bit_cnt  <= 3'd0;
              byte_cnt <= 2'd0;
            end
          end
          PS_CMD: begin
            miso_q <= 1'b0;
            if (sclk_rise) begin
              shift   <= shift_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (shift_in == PSRAM_CMD_READ || shift_in == PSRAM_CMD_WRITE) begin
                  state  <= PS_ADDR;
                  rd_cmd <= (shift_in == PSRAM_CMD_READ);
                end else begin
                  cmd_err_q <= 1'b1;
                  state     <= PS_IGNORE;
                end
              end
            end
          end
          PS_ADDR: begin
            miso_q <= 1'b0;
            if (sclk_rise) begin
              addr    <= {addr[PSRAM_ADDR_BITS-2:0], mosi_level};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd2) begin
                  byte_cnt <= 2'd0;
                  state    <= rd_cmd ? PS_RD_DATA : PS_WR_DATA;
                end
              end
            end
          end
          PS_RD_DATA: begin
            if (sclk_fall) begin
              if (bit_cnt == 3'd0) begin
                // First fall of a byte fetches it and presents its MSB
                shift  <= rd_data;
                miso_q <= rd_data[7];
              end else begin
                shift  <= {shift[6:0], 1'b0};
                miso_q <= shift[6];
              end
            end else if (sclk_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr <= addr + PSRAM_ADDR_BITS'(1);
              end
            end
          end
          PS_WR_DATA: begin
            miso_q <= 1'b0;
            if (sclk_rise) begin
              shift   <= shift_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr <= addr + PSRAM_ADDR_BITS'(1);
              end
            end
          end
          PS_IGNORE: begin
            miso_q <= 1'b0;
          end
          default: begin
            state  <= PS_IDLE;
            miso_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.miso_out    = miso_q;
  assign bus.busy_out    = ~cs_level;
  assign bus.cmd_err_out = cmd_err_q;

  // Pin qualifiers that this protocol has no use for
  assign unused_ok = &{1'b0, sclk_level, mosi_rise, mosi_fall, shift[7]};

endmodule
`default_nettype wire

// File: tb/tb_spi_psram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_psram_responder
// Description : Self-checking bench for the serial PSRAM responder. Drives the
//               SPI pins as a mode-0 master; read data is checked against a
//               scoreboard queue filled when each READ is issued.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_psram_responder;
  import spi_psram_responder_pkg::*;

  typedef struct {
    logic        rd;
    logic [23:0] addr;
    logic [7:0]  data;   // write value, or expected read value
  } vec_t;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b1;

  always #10 clk_in = ~clk_in;

  spi_psram_responder_if bus ();

  spi_psram_responder #(.MEM_ADDR_W(10), .SYNC_STAGES(2)) dut (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int err_cycles = 0;
  int miso_hi_cycles = 0;

  logic [7:0] exp_q[$];
  logic [7:0] tx_buf[8];
  logic [7:0] rx_buf[8];
  logic       hdr_or;
  logic       busy_low_seen;
  vec_t       vecs[12];

  // Count cycles of the error pulse and of miso activity
  always @(posedge clk_in) begin
    if (bus.cmd_err_out === 1'b1) err_cycles++;
    if (bus.miso_out === 1'b1) miso_hi_cycles++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Shift nbits of tx out MSB first, capturing miso on each rising sclk
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.mosi_in = tx[i];
      wait_clk(5);
      bus.sclk_in = 1'b1;
      rx[i] = bus.miso_out;
      if (bus.busy_out !== 1'b1) busy_low_seen = 1'b1;
      wait_clk(5);
      bus.sclk_in = 1'b0;
    end
  endtask

  // Full transaction: opcode, 24-bit address, n data bytes from/to tx_buf/rx_buf
  task automatic txn(input logic [7:0] op, input logic [23:0] addr, input int n);
    logic [7:0] rx;
    busy_low_seen = 1'b0;
    hdr_or = 1'b0;
    bus.cs_in = 1'b0;
    wait_clk(6);
    xfer(op, 8, rx);           hdr_or = hdr_or | (|rx);
    xfer(addr[23:16], 8, rx);  hdr_or = hdr_or | (|rx);
    xfer(addr[15:8], 8, rx);   hdr_or = hdr_or | (|rx);
    xfer(addr[7:0], 8, rx);    hdr_or = hdr_or | (|rx);
    for (int i = 0; i < n; i++) begin
      xfer(tx_buf[i], 8, rx);
      rx_buf[i] = rx;
    end
    wait_clk(5);
    bus.cs_in = 1'b1;
    wait_clk(8);
    check("miso_idle_hdr", 32'(hdr_or), 32'd0);
    check("busy_during_cs", 32'(busy_low_seen), 32'd0);
    if (op == 8'h03) begin
      for (int i = 0; i < n; i++) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else check("rd_data", 32'(rx_buf[i]), 32'(exp_q.pop_front()));
      end
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #1500000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx;
    int e0, m0;

    bus.sclk_in = 1'b0;
    bus.cs_in   = 1'b1;
    bus.mosi_in = 1'b0;
    reset_in    = 1'b1;
    wait_clk(4);
    check("rst_miso", 32'(bus.miso_out), 32'd0);
    check("rst_busy", 32'(bus.busy_out), 32'd0);
    check("rst_cmd_err", 32'(bus.cmd_err_out), 32'd0);
    reset_in = 1'b0;
    wait_clk(4);
    check("post_rst_busy", 32'(bus.busy_out), 32'd0);

    // Single-byte write/read vectors
    vecs[0]  = '{1'b0, 24'h000004, 8'hA5};
    vecs[1]  = '{1'b1, 24'h000004, 8'hA5};
    vecs[2]  = '{1'b0, 24'h000005, 8'h3C};
    vecs[3]  = '{1'b0, 24'h000004, 8'h55};
    vecs[4]  = '{1'b1, 24'h000004, 8'h55};
    vecs[5]  = '{1'b1, 24'h000005, 8'h3C};
    vecs[6]  = '{1'b0, 24'h000123, 8'h9E};
    vecs[7]  = '{1'b1, 24'hFFF123, 8'h9E};
    vecs[8]  = '{1'b0, 24'h000010, 8'h77};
    vecs[9]  = '{1'b1, 24'h000010, 8'h77};
    vecs[10] = '{1'b0, 24'h000200, 8'h01};
    vecs[11] = '{1'b1, 24'h000200, 8'h01};
    for (int k = 0; k < 12; k++) begin
      if (vecs[k].rd) begin
        exp_q.push_back(vecs[k].data);
        tx_buf[0] = 8'h00;
        txn(8'h03, vecs[k].addr, 1);
      end else begin
        tx_buf[0] = vecs[k].data;
        txn(8'h02, vecs[k].addr, 1);
      end
    end
    check("no_cmd_err_valid_ops", 32'(err_cycles), 32'd0);

    // Burst write across the top of the array, then read back
    tx_buf[0] = 8'h11;
    tx_buf[1] = 8'h22;
    txn(8'h02, 24'h0003FF, 2);
    tx_buf[0] = 8'h00;
    tx_buf[1] = 8'h00;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    txn(8'h03, 24'h0003FF, 2);
    exp_q.push_back(8'h22);
    txn(8'h03, 24'h000000, 1);

    // Unsupported opcode: single error pulse, silent for 32 sclk
    e0 = err_cycles;
    m0 = miso_hi_cycles;
    txn(8'h9F, 24'hFFFFFF, 0);
    check("cmd_err_pulse_width", 32'(err_cycles - e0), 32'd1);
    check("miso_quiet_ignore", 32'(miso_hi_cycles - m0), 32'd0);
    exp_q.push_back(8'h55);
    txn(8'h03, 24'h000004, 1);

    // Write aborted after 5 data bits leaves the byte untouched
    bus.cs_in = 1'b0;
    wait_clk(6);
    xfer(8'h02, 8, rx);
    xfer(8'h00, 8, rx);
    xfer(8'h00, 8, rx);
    xfer(8'h10, 8, rx);
    xfer(8'hFF, 5, rx);
    wait_clk(5);
    bus.cs_in = 1'b1;
    wait_clk(8);
    check("abort_busy", 32'(bus.busy_out), 32'd0);
    check("abort_fsm_idle", 32'(dut.state), 32'(PS_IDLE));
    exp_q.push_back(8'h77);
    txn(8'h03, 24'h000010, 1);

    // Reset asserted in the middle of the address phase
    bus.cs_in = 1'b0;
    wait_clk(6);
    xfer(8'h03, 8, rx);
    xfer(8'h00, 8, rx);
    xfer(8'h00, 4, rx);
    check("busy_before_reset", 32'(bus.busy_out), 32'd1);
    #3 reset_in = 1'b1;
    #1;
    check("async_rst_busy", 32'(bus.busy_out), 32'd0);
    check("async_rst_miso", 32'(bus.miso_out), 32'd0);
    check("async_rst_cmd_err", 32'(bus.cmd_err_out), 32'd0);
    check("async_rst_fsm_idle", 32'(dut.state), 32'(PS_IDLE));
    @(negedge clk_in);
    bus.cs_in = 1'b1;
    wait_clk(3);
    reset_in = 1'b0;
    wait_clk(6);
    exp_q.push_back(8'h55);
    txn(8'h03, 24'h000004, 1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
